// File: rtl/ysyx_25060170_id_ex_pkg.sv
// Shared widths, zero constants and payload type for the ID/EX pipeline register.
package ysyx_25060170_id_ex_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PC_W      = 32;
  localparam int unsigned INST_W    = 32;
  localparam int unsigned IMM_W     = 32;
  localparam int unsigned REGADDR_W = 5;

  localparam logic [DATA_W-1:0]    ZERO_DATA = '0;
  localparam logic [PC_W-1:0]      ZERO_PC   = '0;
  localparam logic [INST_W-1:0]    ZERO_INST = '0;
  localparam logic [REGADDR_W-1:0] ZERO_ADDR = '0;

  typedef struct packed {
    logic [7:0]           alusrc;
    logic [3:0]           lsctl;
    logic [1:0]           wbctl;
    logic [1:0]           op1_sel;
    logic [2:0]           op2_sel;
    logic                 load_flag;
    logic                 rd_ena;
    logic [REGADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0]    op1;
    logic [DATA_W-1:0]    op2;
    logic [IMM_W-1:0]     imm;
    logic [INST_W-1:0]    inst;
    logic [PC_W-1:0]      pc;
  } idex_payload_t;

  localparam idex_payload_t PAYLOAD_ZERO = '0;

  // Ones mark fields that survive a bubble; side-effecting control fields are zeroed.
  localparam idex_payload_t BUBBLE_KEEP_MASK = '{
    alusrc: '1, lsctl: '0, wbctl: '0, op1_sel: '1, op2_sel: '1, load_flag: 1'b0,
    rd_ena: 1'b0, rd_addr: '1, op1: '1, op2: '1, imm: '1, inst: '0, pc: '1
  };

  function automatic idex_payload_t bubble_clear(input idex_payload_t p);
    return p & BUBBLE_KEEP_MASK;
  endfunction

endpackage

// File: rtl/ysyx_25060170_id_ex_skid.sv
// Single-entry skid buffer holding one accepted decode payload while EX stalls.
module ysyx_25060170_id_ex_skid
  import ysyx_25060170_id_ex_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  idex_payload_t data_i,
  output logic          valid_o,
  output idex_payload_t data_o
);

  logic          valid_q, valid_d;
  idex_payload_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= PAYLOAD_ZERO;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ysyx_25060170_id_ex.sv
// ID/EX pipeline register with load-use bubble insertion and redirect flush.
// Define YSYX_25060170_IDEX_SKID_EN to add a one-entry skid so ex_ready is registered.
module ysyx_25060170_id_ex
  import ysyx_25060170_id_ex_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  output logic                 ex_ready,
  input  logic                 id_ex_flush,
  input  logic                 ex_flush,
  input  logic [7:0]           alusrc_i,
  input  logic [3:0]           lsctl_i,
  input  logic [1:0]           wbctl_i,
  input  logic [1:0]           op1_sel_i,
  input  logic [2:0]           op2_sel_i,
  input  logic                 load_flag_i,
  input  logic                 rd_ena_i,
  input  logic [REGADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0]    op1_i,
  input  logic [DATA_W-1:0]    op2_i,
  input  logic [IMM_W-1:0]     imm_i,
  input  logic [INST_W-1:0]    inst_i,
  input  logic [PC_W-1:0]      pc_i,
  output logic [7:0]           alusrc_o,
  output logic [3:0]           lsctl_o,
  output logic [1:0]           wbctl_o,
  output logic [1:0]           op1_sel_o,
  output logic [2:0]           op2_sel_o,
  output logic                 load_flag_o,
  output logic                 rd_ena_o,
  output logic [REGADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0]    op1_o,
  output logic [DATA_W-1:0]    op2_o,
  output logic [IMM_W-1:0]     imm_o,
  output logic [INST_W-1:0]    inst_o,
  output logic [PC_W-1:0]      pc_o,
  output logic                 ex_valid,
  input  logic                 exu_ready,
  output logic                 ex_load_ena,
  output logic [CNT_W-1:0]     bubble_cnt
);

  idex_payload_t    in_p, main_q, main_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             main_free, take, bubble;
  logic             skid_valid;
  idex_payload_t    skid_data;

  assign in_p = '{
    alusrc: alusrc_i, lsctl: lsctl_i, wbctl: wbctl_i, op1_sel: op1_sel_i, op2_sel: op2_sel_i,
    load_flag: load_flag_i, rd_ena: rd_ena_i, rd_addr: rd_addr_i, op1: op1_i, op2: op2_i,
    imm: imm_i, inst: inst_i, pc: pc_i
  };

  assign main_free = ~valid_q | exu_ready;
  assign take      = ex_ready & id_valid & ~id_ex_flush & ~ex_flush;
  assign bubble    = ex_ready & id_ex_flush & ~ex_flush;

`ifdef YSYX_25060170_IDEX_SKID_EN
  logic skid_push, skid_pop;

  assign ex_ready  = ~skid_valid;
  assign skid_push = take & ~main_free;
  assign skid_pop  = skid_valid & main_free & ~ex_flush;

  ysyx_25060170_id_ex_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .flush_i (ex_flush),
    .data_i  (in_p),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );
`else
  assign ex_ready   = main_free;
  assign skid_valid = 1'b0;
  assign skid_data  = PAYLOAD_ZERO;
`endif

  always_comb begin
    main_d  = main_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (bubble && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    if (ex_flush) begin
      valid_d = 1'b0;
      main_d  = bubble_clear(main_q);
    end else if (main_free) begin
      if (skid_valid) begin
        valid_d = 1'b1;
        main_d  = skid_data;
      end else if (take) begin
        valid_d = 1'b1;
        main_d  = in_p;
      end else if (bubble) begin
        valid_d = 1'b0;
        main_d  = bubble_clear(main_q);
      end else begin
        valid_d = 1'b0;
      end
    end
    // A bubble seen while a valid entry is still stalled leaves that entry in place.
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q  <= PAYLOAD_ZERO;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      main_q  <= main_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alusrc_o    = main_q.alusrc;
  assign lsctl_o     = main_q.lsctl;
  assign wbctl_o     = main_q.wbctl;
  assign op1_sel_o   = main_q.op1_sel;
  assign op2_sel_o   = main_q.op2_sel;
  assign load_flag_o = main_q.load_flag;
  assign rd_ena_o    = main_q.rd_ena;
  assign rd_addr_o   = main_q.rd_addr;
  assign op1_o       = main_q.op1;
  assign op2_o       = main_q.op2;
  assign imm_o       = main_q.imm;
  assign inst_o      = main_q.inst;
  assign pc_o        = main_q.pc;
  assign ex_valid    = valid_q;
  assign ex_load_ena = valid_q & main_q.load_flag & main_q.rd_ena;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_ysyx_25060170_id_ex.sv
// Scoreboard bench for ysyx_25060170_id_ex: driver queues accepted payloads,
// a negedge monitor checks what EX sees against an occupancy-level model.
module tb_ysyx_25060170_id_ex;

  typedef struct packed {
    logic [7:0]  alusrc;
    logic [3:0]  lsctl;
    logic [1:0]  wbctl;
    logic [1:0]  op1_sel;
    logic [2:0]  op2_sel;
    logic        load_flag;
    logic        rd_ena;
    logic [4:0]  rd_addr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [31:0] inst;
    logic [31:0] pc;
  } pay_t;

`ifdef YSYX_25060170_IDEX_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid = 1'b0, id_ex_flush = 1'b0, ex_flush = 1'b0, exu_ready = 1'b0;
  pay_t in_p = '0;
  pay_t out_p;

  logic        ex_ready, ex_valid, ex_load_ena;
  logic [31:0] bubble_cnt;
  logic [7:0]  alusrc_o;
  logic [3:0]  lsctl_o;
  logic [1:0]  wbctl_o, op1_sel_o;
  logic [2:0]  op2_sel_o;
  logic        load_flag_o, rd_ena_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] op1_o, op2_o, imm_o, inst_o, pc_o;

  ysyx_25060170_id_ex #(.CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .ex_ready    (ex_ready),
    .id_ex_flush (id_ex_flush),
    .ex_flush    (ex_flush),
    .alusrc_i    (in_p.alusrc),
    .lsctl_i     (in_p.lsctl),
    .wbctl_i     (in_p.wbctl),
    .op1_sel_i   (in_p.op1_sel),
    .op2_sel_i   (in_p.op2_sel),
    .load_flag_i (in_p.load_flag),
    .rd_ena_i    (in_p.rd_ena),
    .rd_addr_i   (in_p.rd_addr),
    .op1_i       (in_p.op1),
    .op2_i       (in_p.op2),
    .imm_i       (in_p.imm),
    .inst_i      (in_p.inst),
    .pc_i        (in_p.pc),
    .alusrc_o    (alusrc_o),
    .lsctl_o     (lsctl_o),
    .wbctl_o     (wbctl_o),
    .op1_sel_o   (op1_sel_o),
    .op2_sel_o   (op2_sel_o),
    .load_flag_o (load_flag_o),
    .rd_ena_o    (rd_ena_o),
    .rd_addr_o   (rd_addr_o),
    .op1_o       (op1_o),
    .op2_o       (op2_o),
    .imm_o       (imm_o),
    .inst_o      (inst_o),
    .pc_o        (pc_o),
    .ex_valid    (ex_valid),
    .exu_ready   (exu_ready),
    .ex_load_ena (ex_load_ena),
    .bubble_cnt  (bubble_cnt)
  );

  assign out_p = {alusrc_o, lsctl_o, wbctl_o, op1_sel_o, op2_sel_o, load_flag_o, rd_ena_o,
                  rd_addr_o, op1_o, op2_o, imm_o, inst_o, pc_o};

  always #5 clk = ~clk;

  // Model state: exp_q holds payloads in arrival order; the first occ of them are inside the DUT.
  pay_t   exp_q[$];
  int     occ = 0;
  longint bub_m = 0;
  bit     clr_m = 1'b1;
  bit     pushed = 1'b0;
  bit     done = 1'b0;
  int     n_vec = 0;
  int     n_bad = 0;

  function automatic bit ready_m(input int o, input bit exu);
    if (CAP == 1) return (o == 0) || exu;
    return o < CAP;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic pay_t rand_pay();
    pay_t p;
    p.alusrc    = 8'($urandom);
    p.lsctl     = 4'($urandom);
    p.wbctl     = 2'($urandom);
    p.op1_sel   = 2'($urandom);
    p.op2_sel   = 3'($urandom);
    p.load_flag = 1'($urandom);
    p.rd_ena    = 1'($urandom);
    p.rd_addr   = 5'($urandom);
    p.op1       = $urandom;
    p.op2       = $urandom;
    p.imm       = $urandom;
    p.inst      = $urandom | 32'h1;
    p.pc        = $urandom & 32'hFFFF_FFFC;
    return p;
  endfunction

  // One cycle of stimulus, applied just after the rising edge.
  task automatic cyc(input bit iv, input bit idf, input bit exf, input bit exu, input pay_t p);
    @(posedge clk);
    #2;
    id_valid    = iv;
    id_ex_flush = idf;
    ex_flush    = exf;
    exu_ready   = exu;
    in_p        = p;
    pushed      = 1'b0;
    if (rst && iv && !idf && !exf && ready_m(occ, exu)) begin
      exp_q.push_back(p);
      pushed = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    bit r, bub, cons;
    if (!done) begin
      if (!rst) begin
        chk("rst_ex_valid", 256'(ex_valid), 256'(0));
        chk("rst_ex_ready", 256'(ex_ready), 256'(1));
        chk("rst_bubble_cnt", 256'(bubble_cnt), 256'(0));
        chk("rst_payload", 256'(out_p), 256'(0));
        exp_q.delete();
        occ   = 0;
        bub_m = 0;
        clr_m = 1'b1;
      end else begin
        r = ready_m(occ, exu_ready);
        chk("ex_ready", 256'(ex_ready), 256'(r));
        chk("ex_valid", 256'(ex_valid), 256'(occ > 0));
        chk("bubble_cnt", 256'(bubble_cnt), 256'(bub_m));
        if (occ > 0) begin
          chk("payload", 256'(out_p), 256'(exp_q[0]));
          chk("ex_load_ena", 256'(ex_load_ena), 256'(exp_q[0].load_flag & exp_q[0].rd_ena));
        end else begin
          chk("ex_load_ena_idle", 256'(ex_load_ena), 256'(0));
        end
        if (clr_m)
          chk("bubble_ctl", 256'({rd_ena_o, wbctl_o, lsctl_o, load_flag_o, inst_o}), 256'(0));
        bub  = r && id_ex_flush && !ex_flush;
        cons = (occ > 0) && exu_ready && !ex_flush;
        if (bub && bub_m != CNT_MAX) bub_m++;
        if (ex_flush) begin
          exp_q.delete();
          occ = 0;
        end else begin
          if (cons) begin
            void'(exp_q.pop_front());
            occ--;
          end
          if (pushed) occ++;
        end
        if (occ > 0) clr_m = 1'b0;
        else if (bub || ex_flush) clr_m = 1'b1;
        else if (cons) clr_m = 1'b0;
      end
    end
  end

  initial begin
    pay_t p, z;
    z = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    p = rand_pay(); p.pc = 32'h8000_0004;
    cyc(1, 0, 0, 1, p);
    cyc(1, 1, 0, 1, rand_pay());
    cyc(1, 0, 0, 1, rand_pay());
    cyc(1, 0, 0, 0, rand_pay());
    cyc(1, 0, 0, 0, rand_pay());
    cyc(1, 1, 0, 0, rand_pay());
    cyc(0, 0, 0, 1, z);
    cyc(0, 0, 0, 1, z);
    cyc(1, 0, 0, 1, rand_pay());
    cyc(1, 1, 1, 1, rand_pay());
    p = rand_pay(); p.rd_addr = 5'd5; p.load_flag = 1'b1; p.rd_ena = 1'b1;
    cyc(1, 0, 0, 0, p);
    cyc(0, 1, 0, 1, z);
    cyc(0, 0, 0, 1, z);
    for (int i = 0; i < 5; i++) begin
      p = rand_pay();
      p.pc = 32'(i * 4);
      cyc(i < 3, 0, 0, (i == 0) || (i > 2), p);
    end
    cyc(0, 0, 0, 1, z);
    cyc(0, 0, 0, 1, z);

    repeat (3000)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 2) != 0, rand_pay());

    cyc(1, 0, 0, 1, rand_pay());
    cyc(1, 0, 0, 0, rand_pay());
    @(posedge clk);
    #2;
    rst      = 1'b0;
    id_valid = 1'b0;
    pushed   = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    cyc(1, 0, 0, 1, rand_pay());
    cyc(0, 0, 0, 1, z);
    cyc(0, 0, 0, 1, z);
    @(posedge clk);
    #2 done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25060170_id_ex.md
YSYX_25060170_ID_EX -- requirements
Module: ysyx_25060170_id_ex

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the bubble counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port id_valid, input, 1, decode payload valid.
REQ-005 SHALL have port ex_ready, output, 1, stage can accept the decode payload this cycle.
REQ-006 SHALL have port id_ex_flush, input, 1, load-use stall request from decode; insert a bubble.
REQ-007 SHALL have port ex_flush, input, 1, branch/jump redirect; kill everything held.
REQ-008 SHALL have payload inputs: alusrc_i 8, lsctl_i 4, wbctl_i 2, op1_sel_i 2, op2_sel_i 3, load_flag_i 1, rd_ena_i 1, rd_addr_i 5, op1_i 32, op2_i 32, imm_i 32, inst_i 32, pc_i 32.
REQ-009 SHALL have matching registered outputs with _o suffix (same widths), plus ex_valid output 1.
REQ-010 SHALL have port exu_ready, input, 1, EX consumes the held payload.
REQ-011 SHALL have port ex_load_ena, output, 1, ex_valid & load_flag_o & rd_ena_o.
REQ-012 SHALL have port bubble_cnt, output, CNT_W, number of load-use bubbles inserted.

Function
REQ-013 SHALL set ex_ready = ~ex_valid | exu_ready (macro off); latency input-to-output exactly 1 cycle.
REQ-014 SHALL accept a transfer when id_valid & ex_ready & ~id_ex_flush & ~ex_flush: load all payload, ex_valid<=1.
REQ-015 SHALL insert a bubble when ex_ready & id_ex_flush & ~ex_flush: ex_valid<=0, rd_ena_o, wbctl_o, lsctl_o, load_flag_o, inst_o <=0.
REQ-016 SHALL, when ex_ready & ~id_valid & no flush, set ex_valid<=0 and hold payload unchanged.
REQ-017 SHALL hold all outputs unchanged when ex_ready=0 and no ex_flush (id_ex_flush ignored while stalled).
REQ-018 SHALL on ex_flush clear ex_valid and zero control fields next cycle, regardless of any other input (highest priority).
REQ-019 SHALL increment bubble_cnt on every REQ-015 event, saturating at all-ones.
REQ-020 SHALL force ex_load_ena=0 whenever ex_valid=0.

Reset
REQ-021 SHALL on rst=0 asynchronously clear ex_valid, all payload outputs, skid state and bubble_cnt to 0.
REQ-022 SHALL present ex_ready=1 in the first cycle after reset release; reset mid-stall discards held payload.

Configuration
REQ-023 SHALL, with YSYX_25060170_IDEX_SKID_EN defined, add one skid entry: ex_ready = ~skid_valid (registered, no combinational path from exu_ready).
REQ-024 SHALL with skid enabled capture an accepted transfer into the skid when main register is valid and exu_ready=0; drain skid to main on next exu_ready; order preserved, no loss, no duplication.
REQ-025 SHALL with skid enabled let ex_flush clear both entries; bubbles are never stored in the skid.
REQ-026 SHALL without the macro contain no skid storage and behave per REQ-013.

Structure
REQ-027 SHALL take widths (DATA, PC, INST, IMM, REGADDR) and zero constants from the shared define package; add a bubble-field clear constant there.
REQ-028 SHALL implement the skid as sub-module ysyx_25060170_id_ex_skid, instantiated only under the macro.

Verification
REQ-029 SHALL test: id_valid=1, pc_i=0x80000004, exu_ready=1 -> next cycle ex_valid=1, pc_o=0x80000004.
REQ-030 SHALL test: id_ex_flush=1 with id_valid=1 for 1 cycle -> ex_valid=0, rd_ena_o=0, bubble_cnt 0->1.
REQ-031 SHALL test: exu_ready=0 for 3 cycles with new inputs -> outputs frozen, ex_ready=0 (macro off).
REQ-032 SHALL test: ex_flush=1 together with id_ex_flush=1 and id_valid=1 -> ex_valid=0, bubble_cnt unchanged.
REQ-033 SHALL test: load inst rd_addr=5, load_flag=1 accepted -> ex_load_ena=1; following bubble -> ex_load_ena=0.
REQ-034 SHALL test (macro on): stream pc 0x0,0x4,0x8 with exu_ready toggling 1,0,0,1,1 -> EX sees 0x0,0x4,0x8 once each, in order.
